nubus_master_mc: RTL and testbench
==================================

NUBUS_MASTER_MC -- requirements
Module: nubus_master_mc

Interface
REQ-001 Parameter NCH, default 2: number of local requester channels, legal range 1..8.
REQ-002 Parameter MAX_RETRY, default 3: maximum re-attempts after a try-again-later status, legal range 1..15.
REQ-003 nub_clkn  input  1  NuBus clock; all state updates occur on its rising edge.
REQ-004 nub_resetn  input  1  asynchronous, active-low reset.
REQ-005 nub_rqstn, nub_startn, nub_ackn  input  1 each  observed NuBus RQST/START/ACK, active-low.
REQ-006 nub_tm1n, nub_tm0n  input  1 each  observed TM lines; they carry the status while ACK is asserted.
REQ-007 arb_grant  input  1  arbitration won, from the external arbiter.
REQ-008 ch_req  input  NCH  per-channel transaction request, level, held until ch_done or ch_err.
REQ-009 ch_lock  input  NCH  per-channel locked-sequence request.
REQ-010 ch_tm  input  2*NCH  per-channel TM1/TM0 start code, active-high.
REQ-011 ch_gnt  output  NCH  one-hot channel being served; all-zero when idle.
REQ-012 ch_done, ch_err  output  NCH each  one-cycle completion/error pulses.
REQ-013 arbcy_o, arbdn_o, adrcy_o, dtacy_o, owner_o, busy_o, locked_o  output  1 each  master phase strobes, active-high.
REQ-014 tm1n_o, tm0n_o  output  1 each  TM drive, active-low.

Function
REQ-015 The FSM SHALL have states IDLE, ARB, ADDR, DATA, HOLD.
REQ-016 busy_o SHALL set on a start&~ack cycle, hold while ~ack, and clear the cycle after ack.
REQ-017 IDLE->ARB SHALL occur when any ch_req is set and nub_rqstn=1; the winner SHALL be chosen round-robin, starting from the channel after the one last served (channel 0 after reset), and latched into ch_gnt.
REQ-018 In ARB, arbcy_o=1; arbdn_o SHALL register arbcy&~start, so there is at least 1 cycle in ARB.
REQ-019 ARB->ADDR SHALL occur when arbdn&arb_grant&((~busy&~start)|(busy&ack)); owner_o SHALL set, and locked_o SHALL set if ch_lock of the winner is set.
REQ-020 ADDR SHALL last exactly 1 cycle with adrcy_o=1, and tm1n_o/tm0n_o SHALL equal the inverted ch_tm of the winner; outside ADDR both SHALL be 1.
REQ-021 DATA SHALL hold dtacy_o=1 until ack, then decode status: 00 complete, 01 error, 10 timeout, 11 try-again-later.
REQ-022 On complete, ch_done SHALL pulse for the winner in the cycle after ack.
REQ-023 On error or timeout, ch_err SHALL pulse for the winner.
REQ-024 After ack with locked_o=0, the FSM SHALL go to IDLE and owner_o SHALL clear.
REQ-025 After ack with locked_o=1, the FSM SHALL go to HOLD and keep owner_o.
REQ-026 In HOLD, if the same channel keeps ch_req&ch_lock, the FSM SHALL go to ADDR next cycle without re-arbitration.
REQ-027 In HOLD, if ch_lock drops, locked_o, owner_o and ch_gnt SHALL clear and the FSM SHALL go to IDLE.
REQ-028 Latency: from ch_req in IDLE with the bus free and arb_grant high, adrcy_o SHALL assert in cycle 3 (IDLE, ARB, ARB+arbdn, ADDR).
REQ-029 ch_req deasserted mid-transaction SHALL NOT abort the transaction; its completion pulse SHALL still be issued.
REQ-030 Loss of arb_grant in ARB SHALL keep the FSM in ARB.

Reset
REQ-031 nub_resetn=0 SHALL immediately force IDLE, all strobes 0, ch_gnt/ch_done/ch_err 0, tm1n_o=tm0n_o=1, retry count 0, round-robin pointer 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction without any done or err pulse.

Configuration
REQ-033 With macro NUBUS_MASTER_RETRY_EN defined, status 11 SHALL increment a retry counter and return to ARB with the same channel; ch_err SHALL pulse only after the attempt that exceeds MAX_RETRY.
REQ-034 With NUBUS_MASTER_RETRY_EN defined, the retry counter SHALL clear on ch_done, ch_err or reset.
REQ-035 Without NUBUS_MASTER_RETRY_EN defined, status 11 SHALL pulse ch_err immediately and no counter SHALL exist.

Verification
REQ-036 NCH=2, ch_req=01, bus idle, grant=1, ack with TM=00 after 2 DATA cycles -> adrcy_o in cycle 3, ch_done=01 one pulse, FSM returns to IDLE.
REQ-037 ch_req=11 held for 4 transactions -> ch_gnt sequence 01,10,01,10.
REQ-038 ch_lock=1, 3 back-to-back transactions -> owner_o stays high throughout, only one arbcy_o episode, locked_o clears after ch_lock drops.
REQ-039 With the macro defined and MAX_RETRY=3, status 11 on every attempt -> 4 ADDR phases then ch_err; without the macro -> ch_err after 1 attempt.
REQ-040 nub_resetn pulsed low during DATA -> outputs 0 immediately, no ch_done/ch_err, next request served normally.
REQ-041 Bus busy (start seen, ack at cycle 5) while in ARB with grant -> ADDR only in the cycle after ack.

Source files
------------

// File: rtl/nubus_master_mc.sv
// nubus_master_mc: NuBus master-side transaction controller.
//
// Serves up to NCH local requester channels. Channels are picked round-robin.
// The picked channel then goes through the NuBus phases arbitrate, address and
// data. A locked sequence keeps bus ownership across back-to-back transactions.
//
// Optional feature: define NUBUS_MASTER_RETRY_EN to retry a transaction that
// ends with try-again-later status. Up to MAX_RETRY re-attempts are made. When
// the macro is undefined, try-again-later is reported as an error at once.
//
// Ports:
//   nub_clkn            NuBus clock; state updates on its rising edge
//   nub_resetn          asynchronous active-low reset
//   nub_rqstn           observed RQST (active-low)
//   nub_startn          observed START (active-low)
//   nub_ackn            observed ACK (active-low)
//   nub_tm1n, nub_tm0n  observed TM lines; carry the status while ACK is low
//   arb_grant           arbitration won, from the external arbiter
//   ch_req[NCH]         per-channel request level, held until done/err
//   ch_lock[NCH]        per-channel locked-sequence request
//   ch_tm[2*NCH]        per-channel {TM1,TM0} start code, active-high
//   ch_gnt[NCH]         one-hot channel being served, zero when idle
//   ch_done[NCH]        one-cycle completion pulse
//   ch_err[NCH]         one-cycle error pulse
//   arbcy_o .. locked_o phase strobes, active-high
//   tm1n_o, tm0n_o      TM drive during the address phase, active-low
module nubus_master_mc #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic               nub_clkn,
    input  logic               nub_resetn,
    input  logic               nub_rqstn,
    input  logic               nub_startn,
    input  logic               nub_ackn,
    input  logic               nub_tm1n,
    input  logic               nub_tm0n,
    input  logic               arb_grant,
    input  logic [NCH-1:0]     ch_req,
    input  logic [NCH-1:0]     ch_lock,
    input  logic [2*NCH-1:0]   ch_tm,
    output logic [NCH-1:0]     ch_gnt,
    output logic [NCH-1:0]     ch_done,
    output logic [NCH-1:0]     ch_err,
    output logic               arbcy_o,
    output logic               arbdn_o,
    output logic               adrcy_o,
    output logic               dtacy_o,
    output logic               owner_o,
    output logic               busy_o,
    output logic               locked_o,
    output logic               tm1n_o,
    output logic               tm0n_o
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StAddr,
        StData,
        StHold
    } state_e;

    state_e         state_q, state_d;
    logic           busy_q, busy_d;
    logic           arbdn_q, arbdn_d;
    logic           owner_q, owner_d;
    logic           locked_q, locked_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] err_q, err_d;
    logic [IW-1:0]  idx_q, idx_d;     // index of the channel in ch_gnt
    logic [IW-1:0]  rr_q, rr_d;       // first channel to consider next time

`ifdef NUBUS_MASTER_RETRY_EN
    logic [3:0]     retry_q, retry_d;
`else
    logic           unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
`endif

    logic       start, ack;
    logic [1:0] status;

    assign start  = ~nub_startn;
    assign ack    = ~nub_ackn;
    assign status = {~nub_tm1n, ~nub_tm0n};

    // Round-robin scan that starts at rr_q and wraps around.
    logic          rr_found;
    logic [IW-1:0] rr_win;

    always_comb begin
        logic [IW-1:0] c;
        c        = '0;
        rr_found = 1'b0;
        rr_win   = rr_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            c = IW'((32'(rr_q) + i) % NCH);
            if (!rr_found && ch_req[c]) begin
                rr_found = 1'b1;
                rr_win   = c;
            end
        end
    end

    always_comb begin
        logic terminate;
        terminate = 1'b0;
        state_d   = state_q;
        // Another master's cycle: set on START without ACK, clear after ACK.
        busy_d    = ~ack & (start | busy_q);
        arbdn_d   = 1'b0;
        owner_d   = owner_q;
        locked_d  = locked_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        done_d    = '0;
        err_d     = '0;
`ifdef NUBUS_MASTER_RETRY_EN
        retry_d   = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (rr_found && nub_rqstn) begin
                    state_d        = StArb;
                    idx_d          = rr_win;
                    gnt_d          = '0;
                    gnt_d[rr_win]  = 1'b1;
                    rr_d           = (rr_win == IW'(NCH - 1)) ? '0 : rr_win + IW'(1);
                end
            end
            StArb: begin
                // arbdn only rises after a full ARB cycle with no START seen.
                arbdn_d = ~start;
                if (arbdn_q && arb_grant &&
                    ((!busy_q && !start) || (busy_q && ack))) begin
                    state_d  = StAddr;
                    arbdn_d  = 1'b0;
                    owner_d  = 1'b1;
                    locked_d = ch_lock[idx_q];
                end
            end
            StAddr: begin
                state_d = StData;
            end
            StData: begin
                if (ack) begin
                    terminate = 1'b1;
                    unique case (status)
                        2'b00: done_d = gnt_q;
                        2'b01: err_d  = gnt_q;
                        2'b10: err_d  = gnt_q;
                        2'b11: begin
`ifdef NUBUS_MASTER_RETRY_EN
                            if (retry_q == 4'(MAX_RETRY)) begin
                                err_d = gnt_q;
                            end else begin
                                // Re-arbitrate for the same channel.
                                retry_d   = retry_q + 4'd1;
                                terminate = 1'b0;
                                state_d   = StArb;
                                owner_d   = 1'b0;
                                locked_d  = 1'b0;
                            end
`else
                            err_d = gnt_q;
`endif
                        end
                        default: err_d = gnt_q;
                    endcase
                    if (terminate) begin
                        if (locked_q) begin
                            state_d = StHold;
                        end else begin
                            state_d = StIdle;
                            owner_d = 1'b0;
                            gnt_d   = '0;
                        end
                    end
                end
            end
            StHold: begin
                if (!ch_lock[idx_q]) begin
                    state_d  = StIdle;
                    locked_d = 1'b0;
                    owner_d  = 1'b0;
                    gnt_d    = '0;
                end else if (ch_req[idx_q]) begin
                    state_d = StAddr;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef NUBUS_MASTER_RETRY_EN
        if ((done_d != '0) || (err_d != '0)) begin
            retry_d = 4'd0;
        end
`endif
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            arbdn_q  <= 1'b0;
            owner_q  <= 1'b0;
            locked_q <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            idx_q    <= '0;
            rr_q     <= '0;
`ifdef NUBUS_MASTER_RETRY_EN
            retry_q  <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            arbdn_q  <= arbdn_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
`ifdef NUBUS_MASTER_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        arbcy_o  = (state_q == StArb);
        arbdn_o  = arbdn_q;
        adrcy_o  = (state_q == StAddr);
        dtacy_o  = (state_q == StData);
        owner_o  = owner_q;
        busy_o   = busy_q;
        locked_o = locked_q;
        ch_gnt   = gnt_q;
        ch_done  = done_q;
        ch_err   = err_q;
        if (state_q == StAddr) begin
            {tm1n_o, tm0n_o} = ~ch_tm[{idx_q, 1'b0} +: 2];
        end else begin
            {tm1n_o, tm0n_o} = 2'b11;
        end
    end

endmodule

// File: tb/tb_nubus_master_mc.sv
// Self-checking bench for nubus_master_mc (NCH=2, MAX_RETRY=3).
// The scoreboard holds expected {ch_err, ch_done} pulses. It is filled when a
// request is issued and drained by a monitor whenever the DUT pulses.
module tb_nubus_master_mc;

    localparam int NCH       = 2;
    localparam int MAX_RETRY = 3;
`ifdef NUBUS_MASTER_RETRY_EN
    localparam int RetryAdr  = MAX_RETRY + 1;
`else
    localparam int RetryAdr  = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             nub_resetn;
    logic             nub_rqstn;
    logic             nub_startn;
    logic             ext_ackn;
    logic             slv_ackn = 1'b1;
    logic             slv_tm1n = 1'b1;
    logic             slv_tm0n = 1'b1;
    logic             nub_ackn;
    logic             arb_grant;
    logic [NCH-1:0]   ch_req;
    logic [NCH-1:0]   ch_lock;
    logic [2*NCH-1:0] ch_tm;
    logic [NCH-1:0]   ch_gnt, ch_done, ch_err;
    logic arbcy_o, arbdn_o, adrcy_o, dtacy_o, owner_o, busy_o, locked_o, tm1n_o, tm0n_o;

    assign nub_ackn = slv_ackn & ext_ackn;

    nubus_master_mc #(
        .NCH       (NCH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .nub_clkn   (clk),
        .nub_resetn (nub_resetn),
        .nub_rqstn  (nub_rqstn),
        .nub_startn (nub_startn),
        .nub_ackn   (nub_ackn),
        .nub_tm1n   (slv_tm1n),
        .nub_tm0n   (slv_tm0n),
        .arb_grant  (arb_grant),
        .ch_req     (ch_req),
        .ch_lock    (ch_lock),
        .ch_tm      (ch_tm),
        .ch_gnt     (ch_gnt),
        .ch_done    (ch_done),
        .ch_err     (ch_err),
        .arbcy_o    (arbcy_o),
        .arbdn_o    (arbdn_o),
        .adrcy_o    (adrcy_o),
        .dtacy_o    (dtacy_o),
        .owner_o    (owner_o),
        .busy_o     (busy_o),
        .locked_o   (locked_o),
        .tm1n_o     (tm1n_o),
        .tm0n_o     (tm0n_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [2*NCH-1:0] sb_q[$];

    int slave_wait   = 2;
    logic [1:0] slave_status = 2'b00;

    int arb_eps, adr_cnt, owner_drops, done_cyc, first_adr;
    logic [NCH-1:0] gnt_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Slave model: acks on the slave_wait-th data cycle with slave_status.
    int dcnt = 0;
    always @(negedge clk) begin
        if (dtacy_o) dcnt = dcnt + 1;
        else         dcnt = 0;
        if (dtacy_o && dcnt == slave_wait) begin
            slv_ackn = 1'b0;
            {slv_tm1n, slv_tm0n} = ~slave_status;
        end else begin
            slv_ackn = 1'b1;
            {slv_tm1n, slv_tm0n} = 2'b11;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if ((ch_done | ch_err) != '0) begin
            if (sb_q.size() == 0) check("sb_unexpected", {ch_err, ch_done}, 0);
            else                  check("sb_resp", {ch_err, ch_done}, sb_q.pop_front());
        end
    end

    // Steps until n completion pulses are seen or the budget runs out.
    task automatic wait_events(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        logic prev_arb;
        arb_eps = 0; adr_cnt = 0; owner_drops = 0; done_cyc = -1; first_adr = -1;
        gnt_log.delete();
        prev_arb = arbcy_o;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (arbcy_o && !prev_arb) begin
                arb_eps++;
                gnt_log.push_back(ch_gnt);
            end
            prev_arb = arbcy_o;
            if (adrcy_o) begin
                adr_cnt++;
                if (first_adr < 0) first_adr = cyc;
            end
            if ((ch_done | ch_err) != '0) begin
                seen++;
                done_cyc = cyc;
            end else if (adr_cnt > 0 && !owner_o) begin
                owner_drops++;
            end
        end
        check("evt_count", seen, n);
    endtask

    logic [NCH-1:0] gnt_exp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0]     t4_status[3] = '{2'b11, 2'b01, 2'b10};
    logic [NCH-1:0] t4_ch[3]     = '{2'b10, 2'b01, 2'b10};

    initial begin
        int pulses;
        nub_resetn = 1'b0; nub_rqstn = 1'b1; nub_startn = 1'b1; ext_ackn = 1'b1;
        arb_grant = 1'b1; ch_req = '0; ch_lock = '0; ch_tm = '0;
        #1;
        check("rst_outputs", {arbcy_o, arbdn_o, adrcy_o, dtacy_o, owner_o, busy_o, locked_o,
                              ch_gnt, ch_done, ch_err}, 0);
        check("rst_tm", {tm1n_o, tm0n_o}, 2'b11);
        step(2);
        nub_resetn = 1'b1;
        step(1);

        // Basic transaction, latency and TM drive.
        ch_tm = 4'b0110;
        slave_wait = 2;
        sb_q.push_back(4'b0001);
        ch_req = 2'b01;
        step(1);
        check("t1_arbcy", arbcy_o, 1);
        check("t1_arbdn0", arbdn_o, 0);
        check("t1_tm_idle", {tm1n_o, tm0n_o}, 2'b11);
        step(1);
        check("t1_arbdn1", arbdn_o, 1);
        step(1);
        check("t1_adrcy", adrcy_o, 1);
        check("t1_tm_addr", {tm1n_o, tm0n_o}, 2'b01);
        check("t1_gnt", ch_gnt, 2'b01);
        wait_events(1, 20);
        ch_req = '0;
        check("t1_done_lat", done_cyc, 3);
        step(1);
        check("t1_one_pulse", ch_done, 0);
        check("t1_idle", {arbcy_o, owner_o, ch_gnt}, 0);

        // Round robin from a fresh reset.
        nub_resetn = 1'b0;
        step(1);
        nub_resetn = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) sb_q.push_back({2'b00, gnt_exp[k]});
        ch_req = 2'b11;
        wait_events(4, 80);
        ch_req = '0;
        check("t2_arb_eps", arb_eps, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_gnt%0d", k), (k < gnt_log.size()) ? gnt_log[k] : 2'b00,
                  gnt_exp[k]);

        // Locked back-to-back sequence.
        step(1);
        slave_wait = 1;
        for (int k = 0; k < 3; k++) sb_q.push_back(4'b0001);
        ch_lock = 2'b01;
        ch_req  = 2'b01;
        wait_events(3, 60);
        check("t3_locked", locked_o, 1);
        check("t3_owner", owner_o, 1);
        check("t3_arb_eps", arb_eps, 1);
        check("t3_adr_cnt", adr_cnt, 3);
        check("t3_owner_drops", owner_drops, 0);
        ch_req = '0;
        ch_lock = '0;
        step(1);
        check("t3_release", {locked_o, owner_o, ch_gnt}, 0);

        // Error statuses, including try-again-later.
        for (int r = 0; r < 3; r++) begin
            step(1);
            slave_status = t4_status[r];
            sb_q.push_back({t4_ch[r], 2'b00});
            ch_req = t4_ch[r];
            wait_events(1, 80);
            ch_req = '0;
            check($sformatf("t4_adr%0d", r), adr_cnt, (t4_status[r] == 2'b11) ? RetryAdr : 1);
        end
        slave_status = 2'b00;

        // Reset in the data phase.
        step(1);
        slave_wait = 6;
        ch_req = 2'b10;
        for (int i = 0; i < 10 && !dtacy_o; i++) step(1);
        check("t5_in_data", dtacy_o, 1);
        nub_resetn = 1'b0;
        #1;
        check("t5_rst_outputs", {arbcy_o, arbdn_o, adrcy_o, dtacy_o, owner_o, busy_o, locked_o,
                                 ch_gnt, ch_done, ch_err}, 0);
        check("t5_rst_tm", {tm1n_o, tm0n_o}, 2'b11);
        ch_req = '0;
        @(negedge clk);
        nub_resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if ((ch_done | ch_err) != '0) pulses++;
        end
        check("t5_no_pulse", pulses, 0);
        slave_wait = 2;
        sb_q.push_back(4'b0001);
        ch_req = 2'b01;
        wait_events(1, 30);
        ch_req = '0;
        check("t5_first_adr", first_adr, 3);
        check("t5_done_cyc", done_cyc, 6);

        // Another master owns the bus while we sit in ARB.
        step(1);
        sb_q.push_back(4'b0001);
        ch_req = 2'b01;
        step(1);
        check("t6_arbcy", arbcy_o, 1);
        nub_startn = 1'b0;
        step(1);
        nub_startn = 1'b1;
        check("t6_busy", busy_o, 1);
        check("t6_arbdn0", arbdn_o, 0);
        step(1);
        check("t6_arbdn1", arbdn_o, 1);
        check("t6_wait3", adrcy_o, 0);
        step(1);
        check("t6_wait4", adrcy_o, 0);
        step(1);
        ext_ackn = 1'b0;
        check("t6_wait5", adrcy_o, 0);
        step(1);
        ext_ackn = 1'b1;
        check("t6_adrcy", adrcy_o, 1);
        check("t6_busy_clr", busy_o, 0);
        wait_events(1, 20);
        ch_req = '0;

        // RQST held by someone else, then grant loss, then request dropped mid-flight.
        step(1);
        nub_rqstn = 1'b0;
        ch_req = 2'b10;
        step(3);
        check("t7_rqst_block", arbcy_o, 0);
        nub_rqstn = 1'b1;
        arb_grant = 1'b0;
        sb_q.push_back(4'b0010);
        step(4);
        check("t7_hold_arb", {arbcy_o, arbdn_o, adrcy_o}, 3'b110);
        arb_grant = 1'b1;
        slave_wait = 3;
        step(1);
        check("t7_adrcy", adrcy_o, 1);
        check("t7_gnt", ch_gnt, 2'b10);
        step(1);
        ch_req = '0;
        wait_events(1, 20);
        check("t7_done_cyc", done_cyc, 3);

        step(2);
        check("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
